// File: rtl/svc_rv_ld_unit_pkg.sv
// Shared load-unit definitions: RISC-V load funct3 encodings, FSM states, size decode.
// The states ISSUE1/WAIT1 exist only when SVC_RV_LD_MISALIGN_EN is defined.
package svc_rv_ld_unit_pkg;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LD  = 3'b011;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_LWU = 3'b110;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE0,
        ST_WAIT0,
`ifdef SVC_RV_LD_MISALIGN_EN
        ST_ISSUE1,
        ST_WAIT1,
`endif
        ST_RESP
    } ld_state_t;

    // Access size in bytes; 0 marks an encoding that is illegal for this XLEN.
    function automatic logic [3:0] ld_size(input logic [2:0] funct3, input int unsigned xlen);
        case (funct3)
            FUNCT3_LB, FUNCT3_LBU: return 4'd1;
            FUNCT3_LH, FUNCT3_LHU: return 4'd2;
            FUNCT3_LW:             return 4'd4;
            FUNCT3_LWU:            return (xlen == 64) ? 4'd4 : 4'd0;
            FUNCT3_LD:             return (xlen == 64) ? 4'd8 : 4'd0;
            default:               return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/svc_rv_ld_ext.sv
// Combinational load formatter: shifts the {word1, word0} window down by the byte offset,
// truncates to the access size and sign- or zero-extends to XLEN.
module svc_rv_ld_ext
    import svc_rv_ld_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2*XLEN-1:0]         window,
    input  logic [$clog2(XLEN/8)-1:0] offset,
    input  logic [2:0]                funct3,
    output logic [XLEN-1:0]           data
);

    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] mask;
    logic            sign;
    int unsigned     nbits;

    always_comb begin
        shifted = XLEN'(window >> {offset, 3'b000});
        nbits   = 8 * 32'(ld_size(funct3, XLEN));
        mask    = '0;
        sign    = 1'b0;
        data    = '0;
        if (nbits != 0) begin
            mask = (nbits >= XLEN) ? '1 : ((XLEN'(1) << nbits) - XLEN'(1));
            sign = |(shifted & (XLEN'(1) << (nbits - 1)));
            // funct3[2] set selects the unsigned variants (LBU/LHU/LWU).
            data = (shifted & mask) | ((!funct3[2] && sign) ? ~mask : '0);
        end
    end

endmodule

// File: rtl/svc_rv_ld_unit.sv
// Sequential RISC-V load unit: one request at a time, word-aligned reads, formatted result.
// Define SVC_RV_LD_MISALIGN_EN to split word-crossing loads into two reads instead of faulting.
module svc_rv_ld_unit
    import svc_rv_ld_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [XLEN-1:0] ld_addr,
    input  logic [2:0]      ld_funct3,
    output logic            dmem_ren,
    output logic [XLEN-1:0] dmem_raddr,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [XLEN-1:0] res_data,
    output logic            res_misalign
);

    localparam int unsigned W    = XLEN / 8;
    localparam int unsigned OFFW = $clog2(W);

    ld_state_t         state;
    logic [OFFW-1:0]   off_q;
    logic [2:0]        funct3_q;
    logic [3:0]        req_size;
    logic [2*XLEN-1:0] window;
    logic [XLEN-1:0]   ext_data;
`ifdef SVC_RV_LD_MISALIGN_EN
    logic [XLEN-1:0]   word0_q;
    logic              split;
`else
    logic              req_misalign;
`endif

    assign req_size = ld_size(ld_funct3, XLEN);

`ifdef SVC_RV_LD_MISALIGN_EN
    assign split  = (5'(off_q) + 5'(ld_size(funct3_q, XLEN))) > 5'(W);
    // In WAIT1 the second word arrives on dmem_rdata; word0 was captured earlier.
    assign window = (state == ST_WAIT1) ? {dmem_rdata, word0_q} : {XLEN'(0), dmem_rdata};
`else
    assign req_misalign = (ld_addr[3:0] & (req_size - 4'd1)) != 4'd0;
    assign window       = {XLEN'(0), dmem_rdata};
`endif

    svc_rv_ld_ext #(
        .XLEN(XLEN)
    ) u_ext (
        .window(window),
        .offset(off_q),
        .funct3(funct3_q),
        .data  (ext_data)
    );

    // Load FSM with registered handshake, memory and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            off_q        <= '0;
            funct3_q     <= '0;
            ld_ready     <= 1'b1;
            dmem_ren     <= 1'b0;
            dmem_raddr   <= '0;
            res_valid    <= 1'b0;
            res_data     <= '0;
            res_misalign <= 1'b0;
`ifdef SVC_RV_LD_MISALIGN_EN
            word0_q      <= '0;
`endif
        end else begin
            dmem_ren <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ld_valid) begin
                        off_q    <= ld_addr[OFFW-1:0];
                        funct3_q <= ld_funct3;
                        ld_ready <= 1'b0;
                        if (req_size == 4'd0) begin
                            state        <= ST_RESP;
                            res_valid    <= 1'b1;
                            res_data     <= '0;
                            res_misalign <= 1'b0;
`ifndef SVC_RV_LD_MISALIGN_EN
                        end else if (req_misalign) begin
                            state        <= ST_RESP;
                            res_valid    <= 1'b1;
                            res_data     <= '0;
                            res_misalign <= 1'b1;
`endif
                        end else begin
                            state      <= ST_ISSUE0;
                            dmem_ren   <= 1'b1;
                            dmem_raddr <= {ld_addr[XLEN-1:OFFW], OFFW'(0)};
                        end
                    end
                end
                ST_ISSUE0: state <= ST_WAIT0;
                ST_WAIT0: begin
                    if (dmem_rvalid) begin
`ifdef SVC_RV_LD_MISALIGN_EN
                        word0_q <= dmem_rdata;
                        if (split) begin
                            state      <= ST_ISSUE1;
                            dmem_ren   <= 1'b1;
                            dmem_raddr <= dmem_raddr + XLEN'(W);
                        end else begin
                            state        <= ST_RESP;
                            res_valid    <= 1'b1;
                            res_data     <= ext_data;
                            res_misalign <= 1'b0;
                        end
`else
                        state        <= ST_RESP;
                        res_valid    <= 1'b1;
                        res_data     <= ext_data;
                        res_misalign <= 1'b0;
`endif
                    end
                end
`ifdef SVC_RV_LD_MISALIGN_EN
                ST_ISSUE1: state <= ST_WAIT1;
                ST_WAIT1: begin
                    if (dmem_rvalid) begin
                        state        <= ST_RESP;
                        res_valid    <= 1'b1;
                        res_data     <= ext_data;
                        res_misalign <= 1'b0;
                    end
                end
`endif
                ST_RESP: begin
                    if (res_ready) begin
                        state     <= ST_IDLE;
                        res_valid <= 1'b0;
                        ld_ready  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
